// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters. A round-robin arbiter
// picks one request at a time. The operands are registered onto the ALU
// inputs for one execute cycle, and the ALU result is captured into a
// response register. That response is held until the granted port takes it.
// Each operation passes through IDLE -> EXEC -> RESP, so one operation can
// complete at most every three cycles.
//
// Optional feature (compile-time macro): ALU_ARB_OPCHECK_EN
//   When defined, a granted op code above MAX_CODE is treated as illegal.
//   The ALU then sees code 0 for that op, and the response carries
//   rsp_data_o = 0 with rsp_err_o = 1. When the macro is not defined, every
//   code is forwarded unchanged and rsp_err_o is always 0.
//
// Ports
//   clk_i                      clock, all state changes on the rising edge
//   rst_ni                     synchronous active-low reset
//   req{0,1}_valid_i           request valid
//   req{0,1}_ready_o           request accepted this cycle (combinational)
//   req{0,1}_code_i            ALU op code of the request
//   req{0,1}_a_i / _b_i        operands of the request
//   rsp{0,1}_valid_o           result valid for that port
//   rsp{0,1}_ready_i           result consumed by that port
//   rsp_data_o                 result, shared by both response ports
//   rsp_err_o                  illegal-op flag
//   alu_code_o/alu_a_o/alu_b_o registered drive to the shared ALU
//   alu_result_i               combinational ALU result
//   busy_o                     high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int unsigned        WIDTH    = 32,
    parameter int unsigned        CODE_W   = 4,
    parameter logic [CODE_W-1:0]  MAX_CODE = 4'b1010
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [CODE_W-1:0] req0_code_i,
    input  logic [WIDTH-1:0]  req0_a_i,
    input  logic [WIDTH-1:0]  req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [CODE_W-1:0] req1_code_i,
    input  logic [WIDTH-1:0]  req1_a_i,
    input  logic [WIDTH-1:0]  req1_b_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_err_o,
    output logic [CODE_W-1:0] alu_code_o,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic                last_gnt_q;
    logic                gnt_id_q;
    logic                illegal_q;
    logic [CODE_W-1:0]   alu_code_q;
    logic [WIDTH-1:0]    alu_a_q;
    logic [WIDTH-1:0]    alu_b_q;
    logic [WIDTH-1:0]    rsp_data_q;
    logic                rsp_err_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;
    logic                busy_q;

    logic                gnt_valid;
    logic                gnt_id_d;
    logic [CODE_W-1:0]   gnt_code_d;
    logic [WIDTH-1:0]    gnt_a_d;
    logic [WIDTH-1:0]    gnt_b_d;
    logic                gnt_illegal_d;

    // Round-robin pick. When both ports are valid, the port that did not win
    // last time is granted. A grant is never offered while reset is asserted,
    // so no ready pulse can appear for a request that will not be latched.
    always_comb begin
        gnt_valid  = rst_ni && (state_q == IDLE) && (req0_valid_i || req1_valid_i);
        gnt_id_d   = (req0_valid_i && req1_valid_i) ? ~last_gnt_q : req1_valid_i;
        gnt_code_d = gnt_id_d ? req1_code_i : req0_code_i;
        gnt_a_d    = gnt_id_d ? req1_a_i    : req0_a_i;
        gnt_b_d    = gnt_id_d ? req1_b_i    : req0_b_i;
`ifdef ALU_ARB_OPCHECK_EN
        gnt_illegal_d = (gnt_code_d > MAX_CODE);
`else
        gnt_illegal_d = 1'b0;
`endif
    end

`ifndef ALU_ARB_OPCHECK_EN
    logic unused_max_code;
    assign unused_max_code = ^MAX_CODE;
`endif

    assign req0_ready_o = gnt_valid && !gnt_id_d;
    assign req1_ready_o = gnt_valid &&  gnt_id_d;

    // The ALU input registers double as the operation registers. They are
    // loaded on a grant and keep the last op afterwards. An illegal op is
    // steered to code 0 so the ALU never sees an undefined select.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            gnt_id_q     <= 1'b0;
            illegal_q    <= 1'b0;
            alu_code_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt_id_q   <= gnt_id_d;
                        last_gnt_q <= gnt_id_d;
                        illegal_q  <= gnt_illegal_d;
                        alu_code_q <= gnt_illegal_d ? '0 : gnt_code_d;
                        alu_a_q    <= gnt_a_d;
                        alu_b_q    <= gnt_b_d;
                        busy_q     <= 1'b1;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q   <= illegal_q ? '0 : alu_result_i;
                    rsp_err_q    <= illegal_q;
                    rsp0_valid_q <= !gnt_id_q;
                    rsp1_valid_q <=  gnt_id_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (gnt_id_q ? rsp1_ready_i : rsp0_ready_i) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign alu_code_o   = alu_code_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp0_valid_o = rsp0_valid_q;
    assign rsp1_valid_o = rsp1_valid_q;
    assign busy_o       = busy_q;

endmodule
